// File: rtl/dual_lane_merger.sv
// dual_lane_merger
//   Recombines the two alternating lanes from a round-robin splitter into a
//   single in-order stream. Lane 1 carries the even sequence positions and
//   lane 2 the odd ones. Each lane has a DEPTH-entry FIFO to absorb skew.
//   A registered valid/ready output stage emits words strictly alternating
//   between the lanes, starting with lane 1 after reset.
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   resetn_i        synchronous active-low reset
//   lane1_data_i    word from lane 1 (even positions)
//   lane1_valid_i   lane1_data_i valid
//   lane1_ready_o   lane 1 FIFO not full
//   lane2_data_i    word from lane 2 (odd positions)
//   lane2_valid_i   lane2_data_i valid
//   lane2_ready_o   lane 2 FIFO not full
//   out_data_o      merged word
//   out_valid_o     out_data_o valid
//   out_ready_i     downstream accepts out_data_o
//   merged_count_o  words accepted downstream since reset (wraps at 2^16)
module dual_lane_merger #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [WIDTH-1:0] lane1_data_i,
  input  logic             lane1_valid_i,
  output logic             lane1_ready_o,
  input  logic [WIDTH-1:0] lane2_data_i,
  input  logic             lane2_valid_i,
  output logic             lane2_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      merged_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] PTR_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem1_q [DEPTH];
  logic [WIDTH-1:0] mem2_q [DEPTH];

  logic [AW:0]      wr1_q, wr1_d, rd1_q, rd1_d;
  logic [AW:0]      wr2_q, wr2_d, rd2_q, rd2_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      count_q, count_d;

  logic [AW:0]      occ1, occ2;
  logic             full1, full2, empty1, empty2;
  logic             push1, push2, pop1, pop2, load;
  logic [WIDTH-1:0] head1, head2;

  // Occupancy comes from registered pointers only, so ready has no
  // combinational path from any input and a word just written is not
  // visible to the output stage until the following edge.
  assign occ1   = wr1_q - rd1_q;
  assign occ2   = wr2_q - rd2_q;
  assign full1  = (occ1 == PTR_FULL);
  assign full2  = (occ2 == PTR_FULL);
  assign empty1 = (occ1 == '0);
  assign empty2 = (occ2 == '0);

  assign push1 = lane1_valid_i & ~full1;
  assign push2 = lane2_valid_i & ~full2;

  assign head1 = mem1_q[rd1_q[AW-1:0]];
  assign head2 = mem2_q[rd2_q[AW-1:0]];

  // Strict alternation: only the lane named by sel may feed the output,
  // even if the other lane already holds data.
  assign load = (~out_valid_q | out_ready_i) & (sel_q ? ~empty2 : ~empty1);
  assign pop1 = load & ~sel_q;
  assign pop2 = load & sel_q;

  always_comb begin
    wr1_d       = wr1_q;
    rd1_d       = rd1_q;
    wr2_d       = wr2_q;
    rd2_d       = rd2_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;

    if (push1) wr1_d = wr1_q + PTR_ONE;
    if (push2) wr2_d = wr2_q + PTR_ONE;
    if (pop1)  rd1_d = rd1_q + PTR_ONE;
    if (pop2)  rd2_d = rd2_q + PTR_ONE;

    if (load) begin
      out_data_d  = sel_q ? head2 : head1;
      out_valid_d = 1'b1;
      sel_d       = ~sel_q;
    end else if (out_valid_q && out_ready_i) begin
      // Drained with nothing to replace it; data holds its last value.
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready_i) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr1_q       <= '0;
      rd1_q       <= '0;
      wr2_q       <= '0;
      rd2_q       <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      wr1_q       <= wr1_d;
      rd1_q       <= rd1_d;
      wr2_q       <= wr2_d;
      rd2_q       <= rd2_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push1) mem1_q[wr1_q[AW-1:0]] <= lane1_data_i;
    if (push2) mem2_q[wr2_q[AW-1:0]] <= lane2_data_i;
  end

  assign lane1_ready_o  = ~full1;
  assign lane2_ready_o  = ~full2;
  assign out_data_o     = out_data_q;
  assign out_valid_o    = out_valid_q;
  assign merged_count_o = count_q;

endmodule

// File: tb/tb_dual_lane_merger.sv
module tb_dual_lane_merger;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] l1d, l2d, od;
  logic             l1v, l2v, l1r, l2r, ov, ordy;
  logic [15:0]      cnt;

  dual_lane_merger #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .lane1_data_i(l1d), .lane1_valid_i(l1v), .lane1_ready_o(l1r),
    .lane2_data_i(l2d), .lane2_valid_i(l2v), .lane2_ready_o(l2r),
    .out_data_o(od), .out_valid_o(ov), .out_ready_i(ordy),
    .merged_count_o(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two word queues, a lane pointer, an output slot.
  logic [WIDTH-1:0] q1[$], q2[$];
  bit               msel;
  bit               mvalid;
  logic [WIDTH-1:0] mdata;
  logic [15:0]      mcount;
  int               mtotal;
  bit               model_live = 0;
  bit               p1, p2, ld;

  always @(posedge clk) begin
    if (!resetn) begin
      q1.delete(); q2.delete();
      msel = 0; mvalid = 0; mdata = '0; mcount = '0; mtotal = 0;
    end else begin
      p1 = l1v && (q1.size() < DEPTH);
      p2 = l2v && (q2.size() < DEPTH);
      if (mvalid && ordy) begin
        mcount = mcount + 16'd1;
        mtotal++;
      end
      ld = (!mvalid || ordy) && (msel ? q2.size() > 0 : q1.size() > 0);
      if (ld) begin
        mdata  = msel ? q2.pop_front() : q1.pop_front();
        mvalid = 1;
        msel   = !msel;
      end else if (mvalid && ordy) begin
        mvalid = 0;
      end
      if (p1) q1.push_back(l1d);
      if (p2) q2.push_back(l2d);
    end
    model_live = 1;
  end

  // Per-cycle comparison against the model, plus capture of accepted words.
  logic [WIDTH-1:0] cap[$];
  always @(negedge clk) begin
    if (model_live) begin
      chk("out_valid", 32'(ov), 32'(mvalid));
      chk("out_data", od, mdata);
      chk("lane1_ready", 32'(l1r), 32'(q1.size() < DEPTH));
      chk("lane2_ready", 32'(l2r), 32'(q2.size() < DEPTH));
      chk("merged_count", 32'(cnt), 32'(mcount));
      if (resetn && ov && ordy) cap.push_back(od);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_cap(input string name, input logic [WIDTH-1:0] exp[$]);
    chk({name, "_len"}, 32'(cap.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk(name, cap[i], exp[i]);
  endtask

  logic [WIDTH-1:0] exp[$];
  bit               done;

  initial begin
    resetn = 1'b0; ordy = 1'b0;
    l1v = 1'b0; l2v = 1'b0; l1d = '0; l2d = '0;
    idle(2);
    // Reset state
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_out_data", od, 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_ready1", 32'(l1r), 32'd1);
    chk("rst_ready2", 32'(l2r), 32'd1);
    resetn = 1'b1;

    // Ordered merge
    ordy = 1'b1;
    cap.delete();
    for (int i = 0; i < 6; i++) begin
      l1v = (i % 2 == 0); l2v = (i % 2 == 1);
      if (i % 2 == 0) l1d = 32'hA000_0000 + 32'(i); else l2d = 32'hA000_0000 + 32'(i);
      tick();
    end
    l1v = 0; l2v = 0;
    idle(4);
    exp = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002,
            32'hA000_0003, 32'hA000_0004, 32'hA000_0005};
    chk_cap("merge_seq", exp);
    chk("merge_count", 32'(cnt), 32'd6);

    // Skew: odd words arrive first
    cap.delete();
    l2v = 1; l2d = 32'hB000_0001; tick();
    l2d = 32'hB000_0003; tick();
    l2v = 0;
    idle(3);
    chk("skew_wait", 32'(ov), 32'd0);
    l1v = 1; l1d = 32'hB000_0000; tick();
    l1v = 0;
    chk("skew_nobypass", 32'(ov), 32'd0);
    tick();
    chk("skew_b0_valid", 32'(ov), 32'd1);
    chk("skew_b0_data", od, 32'hB000_0000);
    tick();
    chk("skew_b1_data", od, 32'hB000_0001);
    tick();
    chk("skew_stall_b2", 32'(ov), 32'd0);
    exp = '{32'hB000_0000, 32'hB000_0001};
    chk_cap("skew_seq1", exp);
    l1v = 1; l1d = 32'hB000_0002; tick();
    l1v = 0;
    idle(3);
    exp = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    chk_cap("skew_seq2", exp);

    // Full FIFO under back-pressure, then hold stability with lane 2 writing
    ordy = 0;
    cap.delete();
    l1v = 1;
    for (int i = 0; i < 5; i++) begin
      l1d = 32'hD000_0000 + 32'(2 * i);
      tick();
    end
    l1v = 0;
    chk("full_ready1", 32'(l1r), 32'd0);
    chk("full_out_valid", 32'(ov), 32'd1);
    chk("full_out_data", od, 32'hD000_0000);
    for (int i = 0; i < 10; i++) begin
      l2v = (i < 4);
      l2d = 32'hD000_0001 + 32'(2 * i);
      tick();
      chk("hold_data", od, 32'hD000_0000);
      chk("hold_valid", 32'(ov), 32'd1);
    end
    l2v = 0;
    chk("hold_ready2", 32'(l2r), 32'd0);
    ordy = 1;
    tick();
    chk("release_ready1_before_pop", 32'(l1r), 32'd0);
    tick();
    chk("release_ready1_after_pop", 32'(l1r), 32'd1);
    idle(10);
    exp.delete();
    for (int i = 0; i < 9; i++) exp.push_back(32'hD000_0000 + 32'(i));
    chk_cap("bp_seq", exp);

    // Reset mid-stream with words buffered
    ordy = 0;
    l1v = 1;
    for (int i = 0; i < 3; i++) begin
      l1d = 32'hF000_0000 + 32'(2 * i);
      tick();
    end
    l1v = 0;
    resetn = 0;
    tick();
    resetn = 1;
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_out_data", od, 32'd0);
    chk("midrst_count", 32'(cnt), 32'd0);
    chk("midrst_ready1", 32'(l1r), 32'd1);
    chk("midrst_ready2", 32'(l2r), 32'd1);
    ordy = 1;
    cap.delete();
    l2v = 1; l2d = 32'hC000_0001; tick();
    l2v = 0;
    idle(3);
    chk("midrst_c1_held", 32'(ov), 32'd0);
    l1v = 1; l1d = 32'hC000_0000; tick();
    l1v = 0;
    idle(4);
    exp = '{32'hC000_0000, 32'hC000_0001};
    chk_cap("midrst_seq", exp);
    chk("midrst_count2", 32'(cnt), 32'd2);

    // Counter wrap after 65537 handshakes
    resetn = 0; tick(); resetn = 1;
    l1v = 1; l2v = 1; ordy = 1;
    done = 0;
    for (int c = 0; c < 70000 && !done; c++) begin
      l1d = 32'(c);
      l2d = ~32'(c);
      tick();
      if (mtotal >= 65537) done = 1;
    end
    l1v = 0; l2v = 0; ordy = 0;
    chk("wrap_budget", 32'(done), 32'd1);
    chk("wrap_count", 32'(cnt), 32'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
